// File: rtl/mem_responder.sv
// Word-wide memory responder with a programmable wait-state count and one-cycle ready pulse.
// Optional alignment fault reporting is enabled by defining MEM_ALIGN_FAULT_EN.
module mem_responder #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mread,
    input  logic        Mwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        fault
);

    localparam int unsigned DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-3:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                wr_q;
    logic [31:0]         rdata_q;
    logic                ready_q;
    logic                busy_q;
    logic [31:0]         mem [DEPTH];

    logic                req;
    logic                accept;
    logic                enter_resp;
    logic [ADDR_W-3:0]   acc_idx;
    logic [31:0]         acc_wdata;
    logic                acc_wr;
    logic                acc_mis;
    logic                mem_we;
    logic                mem_re;

`ifdef MEM_ALIGN_FAULT_EN
    logic                mis_q;
    logic                fault_q;
`endif

    // With WAIT=0 the access happens on the acceptance edge, so the live inputs are used there.
    always_comb begin
        req        = Mread | Mwrite;
        accept     = (state_q == S_IDLE) && req;
        acc_idx    = accept ? addr[ADDR_W-1:2] : idx_q;
        acc_wdata  = accept ? wdata : wdata_q;
        acc_wr     = accept ? Mwrite : wr_q;
`ifdef MEM_ALIGN_FAULT_EN
        acc_mis    = accept ? (addr[1:0] != 2'b00) : mis_q;
`else
        acc_mis    = 1'b0;
`endif
        enter_resp = (accept && (WAIT == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));
        mem_we     = enter_resp && acc_wr && !acc_mis;
        mem_re     = enter_resp && !acc_wr && !acc_mis;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MEM_ALIGN_FAULT_EN
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef MEM_ALIGN_FAULT_EN
            fault_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        idx_q   <= addr[ADDR_W-1:2];
                        wdata_q <= wdata;
                        wr_q    <= Mwrite;
`ifdef MEM_ALIGN_FAULT_EN
                        mis_q   <= (addr[1:0] != 2'b00);
`endif
                        busy_q  <= 1'b1;
                        if (WAIT == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT);
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_resp) begin
                ready_q <= 1'b1;
`ifdef MEM_ALIGN_FAULT_EN
                fault_q <= acc_mis;
`endif
            end
            if (mem_re) begin
                rdata_q <= mem[acc_idx];
            end
        end
    end

    // Array is not reset; the reset gate drops a write whose final edge coincides with reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;

`ifdef MEM_ALIGN_FAULT_EN
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W];
    assign fault       = fault_q;
`else
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W], addr[1:0]};
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of accesses scored through an expectation queue,
// plus hand sequences for back-to-back strobes, WAIT=0 streaming and mid-access reset.
module tb_mem_responder;

    localparam int unsigned AW = 12;
    localparam int unsigned W2 = 2;

    logic        clk;
    logic        reset;
    logic        Mread, Mwrite;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, busy, fault;

    logic        m0_rd, m0_wr;
    logic [31:0] m0_addr, m0_wdata;
    logic [31:0] r0_rdata;
    logic        r0_ready, r0_busy, r0_fault;

    mem_responder #(.ADDR_W(AW), .WAIT(W2)) dut (
        .clk(clk), .reset(reset), .Mread(Mread), .Mwrite(Mwrite),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .ready(ready), .busy(busy), .fault(fault)
    );

    mem_responder #(.ADDR_W(AW), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .Mread(m0_rd), .Mwrite(m0_wr),
        .addr(m0_addr), .wdata(m0_wdata), .rdata(r0_rdata),
        .ready(r0_ready), .busy(r0_busy), .fault(r0_fault)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        fault;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [1 << (AW - 2)];
    logic [31:0] rd_m;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every ready pulse of the WAIT=2 instance must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (!reset && ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_rdata"}, rdata, e.rdata);
                check({e.name, "_fault"}, 32'(fault), 32'(e.fault));
            end
        end
    end

    // Reference behaviour of one access; returns the expectation to queue.
    function automatic exp_t model(logic rd, logic wr, logic [31:0] a, logic [31:0] d, int c, string nm);
        exp_t e;
        logic mis;
        logic [AW-3:0] ix;
        ix = a[AW-1:2];
`ifdef MEM_ALIGN_FAULT_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (!mis) begin
            if (wr) mem_m[ix] = d;
            else if (rd) rd_m = mem_m[ix];
        end
        e.cyc   = c;
        e.rdata = rd_m;
        e.fault = mis;
        e.name  = nm;
        return e;
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input string nm);
        sb.push_back(model(rd, wr, a, d, cyc + 1 + int'(W2), nm));
        Mread  = rd;
        Mwrite = wr;
        addr   = a;
        wdata  = d;
        step();
        Mread  = 1'b0;
        Mwrite = 1'b0;
        for (int i = 0; i <= int'(W2); i++) begin
            check({nm, "_busy"}, 32'(busy), 32'd1);
            step();
        end
        check({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    vec_t        tbl[8];
    logic [31:0] v0[4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rd_m  = '0;
        for (int i = 0; i < (1 << (AW - 2)); i++) mem_m[i] = '0;

        tbl[0] = '{rd: 1'b0, wr: 1'b1, a: 32'h0000_0010, d: 32'hDEAD_BEEF};
        tbl[1] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_0010, d: 32'h0};
        tbl[2] = '{rd: 1'b0, wr: 1'b1, a: 32'h0000_0040, d: 32'h1234_5678};
        tbl[3] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_1040, d: 32'h0};
        tbl[4] = '{rd: 1'b0, wr: 1'b1, a: 32'h0000_0024, d: 32'h0000_0001};
        tbl[5] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_0024, d: 32'h0};
        tbl[6] = '{rd: 1'b1, wr: 1'b1, a: 32'h0000_0020, d: 32'hA5A5_A5A5};
        tbl[7] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_0020, d: 32'h0};
        v0[0] = 32'h1111_0000; v0[1] = 32'h2222_0004; v0[2] = 32'h3333_0008; v0[3] = 32'h4444_000C;

        reset = 1'b1;
        Mread = 1'b0; Mwrite = 1'b0; addr = '0; wdata = '0;
        m0_rd = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        step();
        step();
        check("reset_rdata", rdata, 32'h0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        step();

        // WAIT=0 instance: preload, then hold Mread high and expect a pulse every second cycle.
        for (int j = 0; j < 4; j++) begin
            m0_wr = 1'b1; m0_addr = 32'(j * 4); m0_wdata = v0[j];
            step();
            m0_wr = 1'b0;
            step();
        end
        m0_rd = 1'b1;
        m0_addr = 32'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("w0_ready", 32'(r0_ready), 32'((i % 2) == 0));
            check("w0_busy", 32'(r0_busy), 32'((i % 2) == 0));
            if ((i % 2) == 0) begin
                check("w0_rdata", r0_rdata, v0[i / 2]);
                m0_addr = 32'((i / 2 + 1) * 4);
            end
        end
        m0_rd = 1'b0;
        check("w0_fault", 32'(r0_fault), 32'd0);
        step();

        for (int k = 0; k < 8; k++) begin
            access(tbl[k].rd, tbl[k].wr, tbl[k].a, tbl[k].d, $sformatf("vec%0d", k));
        end

        // Strobe held through two accesses: the second is accepted only after the mandatory IDLE cycle.
        sb.push_back(model(1'b1, 1'b0, 32'h0000_0010, 32'h0, cyc + 1 + int'(W2), "hold_a"));
        sb.push_back(model(1'b1, 1'b0, 32'h0000_0010, 32'h0, cyc + 1 + int'(W2) + int'(W2) + 2, "hold_b"));
        Mread = 1'b1; addr = 32'h0000_0010;
        for (int i = 0; i < 5; i++) step();
        Mread = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("hold_idle", 32'(busy), 32'd0);

        access(1'b0, 1'b1, 32'h0000_0030, 32'h0, "pre30");

        // Reset during WAIT discards the pending write and never pulses ready.
        Mwrite = 1'b1; addr = 32'h0000_0030; wdata = 32'hFFFF_FFFF;
        step();
        Mwrite = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        step();
        check("abort_ready_hold", 32'(ready), 32'd0);
        step();
        reset = 1'b0;
        rd_m = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_quiet", 32'({ready, busy}), 32'd0);
        end
        access(1'b1, 1'b0, 32'h0000_0030, 32'h0, "rd30_after_abort");

        access(1'b0, 1'b1, 32'h0000_0031, 32'hC0DE_0031, "wr31");
        access(1'b1, 1'b0, 32'h0000_0030, 32'h0, "rd30");
        access(1'b1, 1'b0, 32'h0000_0013, 32'h0, "rd13");

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
